// File: rtl/fetch_issue_queue.sv
// Fetch front end: issues sequential instruction fetches under a credit limit,
// decodes the format of each returned word and presents the oldest one to the decoder.
module fetch_issue_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_format,
    output logic [25:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_illegal
);
    localparam int unsigned    PTR_W      = $clog2(DEPTH);
    localparam int unsigned    CNT_W      = PTR_W + 1;
    localparam int unsigned    DROP_W     = CNT_W + 4;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [3:0]  format;
        logic        illegal;
        logic [25:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t            queue_mem [DEPTH];
    entry_t            new_entry;
    entry_t            head_entry;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  inflight;
    logic [DROP_W-1:0] drop;
    logic [31:0]       fetch_pc;
    logic [CNT_W:0]    credit;
    logic              push;
    logic              pop;
    logic              discard;
    logic              flush_eats_valid;

    assign credit    = {1'b0, occupancy} + {1'b0, inflight};
    assign imem_req  = rst_n & ~flush & (credit < CREDIT_MAX);
    assign imem_addr = fetch_pc;

    assign out_valid = (occupancy != '0);
    assign pop       = out_valid & out_ready & ~flush;
    assign discard   = imem_valid & (drop != '0);
    assign push      = rst_n & imem_valid & ~flush & (drop == '0);

    // A response landing in the flush cycle is one of the outstanding ones, so it is not counted again.
    assign flush_eats_valid = imem_valid & ((drop != '0) | (inflight != '0));

    // Requests are contiguous since the last flush, so the oldest in-flight pc is recoverable from fetch_pc.
    always_comb begin
        new_entry      = '0;
        new_entry.inst = imem_rdata[25:0];
        new_entry.pc   = fetch_pc - (32'(inflight) << 2);
        if (imem_rdata[29:26] != 4'b0000) begin
            new_entry.illegal = 1'b1;
        end else begin
            case (imem_rdata[31:30])
                2'b00:   new_entry.format = 4'b0100;
                2'b01:   new_entry.format = 4'b0001;
                2'b10:   new_entry.format = 4'b0010;
                default: new_entry.format = 4'b1000;
            endcase
        end
    end

    assign head_entry  = out_valid ? queue_mem[head] : '0;
    assign out_format  = head_entry.format;
    assign out_illegal = head_entry.illegal;
    assign out_inst    = head_entry.inst;
    assign out_pc      = head_entry.pc;

    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[tail] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            occupancy <= '0;
            inflight  <= '0;
            drop      <= '0;
            head      <= '0;
            tail      <= '0;
        end else if (flush) begin
            fetch_pc  <= flush_pc & ~32'h3;
            occupancy <= '0;
            inflight  <= '0;
            head      <= '0;
            tail      <= '0;
            drop      <= drop + DROP_W'(inflight) - DROP_W'(flush_eats_valid);
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight  <= inflight + CNT_W'(imem_req) - CNT_W'(push);
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (discard) begin
                drop <= drop - DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Bench for fetch_issue_queue: directed scenarios with literal expectations plus a
// queue-based reference model that is compared against the DUT on every falling edge.
module tb_fetch_issue_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_format;
    logic [25:0] out_inst;
    logic [31:0] out_pc;
    logic        out_illegal;

    fetch_issue_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_format(out_format),
        .out_inst(out_inst), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] tbl [16];
    rsp_t        mem_q [$];
    ent_t        m_q [$];
    logic [31:0] m_pend [$];
    int          m_drop = 0;
    logic [31:0] m_fetch_pc = RESET_PC;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return tbl[a[5:2]] ^ {6'b0, a[25:0]};
    endfunction

    function automatic logic [3:0] fmt_of(input logic [31:0] w);
        logic [3:0] by_major [4];
        by_major[0] = 4'b0100;
        by_major[1] = 4'b0001;
        by_major[2] = 4'b0010;
        by_major[3] = 4'b1000;
        return (w[29:26] != 4'b0000) ? 4'b0000 : by_major[w[31:30]];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // One clock: memory response and control inputs change just after the rising edge.
    task automatic applyStimulus(input bit f, input logic [31:0] fpc, input bit rdy);
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = word_at(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        flush     = f;
        flush_pc  = fpc;
        out_ready = rdy;
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, rdy);
    endtask

    task automatic assertReset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        flush      = 1'b0;
        #1;
    endtask

    task automatic releaseReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        cyc        = 0;
        imem_valid = 1'b0;
        flush      = 1'b0;
        #1;
    endtask

    // Reference model and memory: compare against the model, then advance it as the next edge will.
    always @(negedge clk) begin : model_cmp
        bit          exp_req;
        bit          exp_valid;
        ent_t        h;
        ent_t        e;
        rsp_t        r;
        logic [31:0] pc;
        if (!rst_n) begin
            m_q.delete();
            m_pend.delete();
            mem_q.delete();
            m_drop     = 0;
            m_fetch_pc = RESET_PC;
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
            checkOutput("rst_imem_addr", imem_addr, RESET_PC);
            checkOutput("rst_out_illegal", 32'(out_illegal), 32'd0);
            checkOutput("rst_out_format", 32'(out_format), 32'd0);
            checkOutput("rst_out_inst", 32'(out_inst), 32'd0);
            checkOutput("rst_out_pc", out_pc, 32'd0);
        end else begin
            exp_req   = !flush && (m_q.size() + m_pend.size() < DEPTH);
            exp_valid = (m_q.size() != 0);
            checkOutput("m_imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) checkOutput("m_imem_addr", imem_addr, m_fetch_pc);
            checkOutput("m_out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                h = m_q[0];
                checkOutput("m_out_pc", out_pc, h.pc);
                checkOutput("m_out_inst", 32'(out_inst), 32'(h.word[25:0]));
                checkOutput("m_out_format", 32'(out_format), 32'(fmt_of(h.word)));
                checkOutput("m_out_illegal", 32'(out_illegal), 32'(h.word[29:26] != 4'b0000));
            end
            if (imem_req) begin
                r.due  = cyc + lat;
                r.addr = imem_addr;
                mem_q.push_back(r);
            end
            if (flush) begin
                if (imem_valid) begin
                    if (m_drop > 0) m_drop--;
                    else if (m_pend.size() > 0) void'(m_pend.pop_front());
                end
                m_drop += m_pend.size();
                m_pend.delete();
                m_q.delete();
                m_fetch_pc = {flush_pc[31:2], 2'b00};
            end else begin
                if (exp_valid && out_ready) void'(m_q.pop_front());
                if (imem_valid) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else if (m_pend.size() > 0) begin
                        pc     = m_pend.pop_front();
                        e.pc   = pc;
                        e.word = imem_rdata;
                        m_q.push_back(e);
                    end
                end
                if (exp_req) begin
                    m_pend.push_back(m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        #100000;
        bad++;
        $display("[TB] FAIL watchdog: time=%0t limit=100000", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        tbl[0]  = 32'h4000_0000; tbl[1]  = 32'hC000_0000; tbl[2]  = 32'h0400_0000; tbl[3]  = 32'h8000_0000;
        tbl[4]  = 32'h0000_0000; tbl[5]  = 32'h7C00_0000; tbl[6]  = 32'h4123_4567; tbl[7]  = 32'hC3FF_FFFF;
        tbl[8]  = 32'h83AB_CDEF; tbl[9]  = 32'h2000_0000; tbl[10] = 32'h0155_5555; tbl[11] = 32'h4800_0001;
        tbl[12] = 32'hC000_0ABC; tbl[13] = 32'h8000_1234; tbl[14] = 32'h0000_0FFF; tbl[15] = 32'h5000_0000;
        rst_n = 1'b1; flush = 1'b0; flush_pc = 32'h0; out_ready = 1'b1;
        imem_valid = 1'b0; imem_rdata = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_req", 32'(imem_req), 32'd0);
        checkOutput("reset_addr", imem_addr, RESET_PC);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_format", 32'(out_format), 32'd0);

        // Latency 1, decoder always ready: streaming fetch and format decode.
        releaseReset();
        checkOutput("a_req0", 32'(imem_req), 32'd1);
        checkOutput("a_addr0", imem_addr, 32'h0);
        checkOutput("a_valid0", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("a_addr1", imem_addr, 32'h4);
        checkOutput("a_valid1", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("a_valid2", 32'(out_valid), 32'd1);
        checkOutput("a_pc2", out_pc, 32'h0);
        checkOutput("a_fmt_i5", 32'(out_format), 32'h1);
        checkOutput("a_inst2", 32'(out_inst), 32'h0);
        checkOutput("a_addr2", imem_addr, 32'h8);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("a_pc3", out_pc, 32'h4);
        checkOutput("a_fmt_mi10", 32'(out_format), 32'h8);
        checkOutput("a_inst3", 32'(out_inst), 32'h4);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("a_pc4", out_pc, 32'h8);
        checkOutput("a_fmt_illegal", 32'(out_format), 32'h0);
        checkOutput("a_illegal", 32'(out_illegal), 32'd1);
        checkOutput("a_inst4", 32'(out_inst), 32'h8);

        // Decoder stalled: credit allows exactly DEPTH requests, then fetch resumes at 16.
        assertReset();
        out_ready = 1'b0;
        releaseReset();
        for (int k = 0; k < 4; k++) begin
            checkOutput("b_req", 32'(imem_req), 32'd1);
            checkOutput("b_addr", imem_addr, 32'(k * 4));
            applyStimulus(1'b0, 32'h0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput("b_stall_req", 32'(imem_req), 32'd0);
            checkOutput("b_stall_valid", 32'(out_valid), 32'd1);
            checkOutput("b_stall_pc", out_pc, 32'h0);
            applyStimulus(1'b0, 32'h0, k == 2);
        end
        checkOutput("b_release_req", 32'(imem_req), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("b_resume_req", 32'(imem_req), 32'd1);
        checkOutput("b_resume_addr", imem_addr, 32'h10);
        checkOutput("b_resume_pc", out_pc, 32'h4);

        // Queue holding DEPTH-1 with a response and a pop on the same edge.
        assertReset();
        out_ready = 1'b0;
        releaseReset();
        idle(3, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("f_req_full", 32'(imem_req), 32'd0);
        checkOutput("f_pc4", out_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("f_pc5", out_pc, 32'h4);
        checkOutput("f_addr5", imem_addr, 32'h10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("f_order_valid", 32'(out_valid), 32'd1);
            checkOutput("f_order_pc", out_pc, 32'(8 + 4 * k));
        end

        // Reset with three entries queued.
        assertReset();
        out_ready = 1'b0;
        releaseReset();
        idle(4, 1'b0);
        checkOutput("c_valid_before", 32'(out_valid), 32'd1);
        assertReset();
        checkOutput("c_valid_now", 32'(out_valid), 32'd0);
        checkOutput("c_req_now", 32'(imem_req), 32'd0);
        checkOutput("c_pc_now", out_pc, 32'h0);
        checkOutput("c_inst_now", 32'(out_inst), 32'h0);
        out_ready = 1'b1;
        releaseReset();
        checkOutput("c_restart_req", 32'(imem_req), 32'd1);
        checkOutput("c_restart_addr", imem_addr, RESET_PC);
        idle(2, 1'b1);
        checkOutput("c_restart_pc", out_pc, RESET_PC);

        // Latency 3, flush with two requests in flight.
        assertReset();
        lat = 3;
        releaseReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h103, 1'b1);
        checkOutput("d_flush_req", 32'(imem_req), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("d_redirect_req", 32'(imem_req), 32'd1);
        checkOutput("d_redirect_addr", imem_addr, 32'h100);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("d_drop_valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("d_first_valid", 32'(out_valid), 32'd1);
        checkOutput("d_first_pc", out_pc, 32'h100);
        checkOutput("d_first_inst", 32'(out_inst), 32'h100);

        // Latency 2, a response arrives in the flush cycle itself.
        assertReset();
        lat = 2;
        releaseReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b1);
        checkOutput("e_flush_req", 32'(imem_req), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("e_redirect_addr", imem_addr, 32'h200);
        for (int k = 0; k < 3; k++) begin
            checkOutput("e_drop_valid", 32'(out_valid), 32'd0);
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        checkOutput("e_first_valid", 32'(out_valid), 32'd1);
        checkOutput("e_first_pc", out_pc, 32'h200);

        // Redirect near the top of the address space: fetch_pc wraps to 0.
        applyStimulus(1'b1, 32'hFFFF_FFFA, 1'b1);
        checkOutput("g_flush_req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("g_wrap_addr", imem_addr, 32'hFFFF_FFF8 + 32'(4 * k));
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("g_wrap_pc", out_pc, 32'hFFFF_FFF8 + 32'(4 * k));
        end

        // Mixed stalls and flushes, checked by the model alone.
        for (int i = 0; i < 60; i++) begin
            applyStimulus((i == 25) || (i == 41), 32'h40 + 32'(i), (i % 3) != 2);
        end
        idle(8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
